// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage RV64 core: datapath width,
// ALUOp encodings, major opcodes and the ID/EX control bundle.
package rv_pipe_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] ALUOP_LDST = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP_32  = 7'b0111011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_NOP = '0;

  // True when the bundle can change architectural or memory state.
  function automatic logic ctrl_has_effect(input id_ex_ctrl_t c);
    return c.regwrite | c.memwrite | c.branch;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use hazard detector. Drives decode's bubble input and
// the PC / IF/ID write enables; a flush overrides any stall request.
module hazard_unit
  import rv_pipe_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       flush,
  output logic       hazard,
  output logic       bubble,
  output logic       pc_write,
  output logic       if_id_write
);

  logic rd_match;

  // Both sources are compared whatever the format, so the check is conservative.
  always_comb begin
    rd_match    = (ex_rd == id_rs1) | (ex_rd == id_rs2);
    hazard      = ex_valid & ex_memread & (ex_rd != 5'd0) & id_valid & rd_match;
    bubble      = hazard & ~flush;
    pc_write    = ~bubble;
    if_id_write = ~bubble;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall insertion, branch flush and
// saturating stall/flush counters. One-cycle latency from ID to EX.
module id_ex_stage
  import rv_pipe_pkg::*;
#(
  parameter int XLEN  = rv_pipe_pkg::XLEN,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic [6:0]       id_funct7,
  input  logic [XLEN-1:0]  id_rdata1,
  input  logic [XLEN-1:0]  id_rdata2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_branch,
  input  logic             id_memread,
  input  logic             id_memtoreg,
  input  logic             id_memwrite,
  input  logic             id_alusrc,
  input  logic             id_regwrite,
  input  logic [1:0]       id_aluop,
  input  logic             flush,
  output logic             bubble,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rdata1,
  output logic [XLEN-1:0]  ex_rdata2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic [6:0]       ex_funct7,
  output logic             ex_branch,
  output logic             ex_memread,
  output logic             ex_memtoreg,
  output logic             ex_memwrite,
  output logic             ex_alusrc,
  output logic             ex_regwrite,
  output logic [1:0]       ex_aluop,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ex_valid qualifies the EX slot: when 0 every ex_* control bit is 0 and
  // the entry has no architectural effect. There is no ready/backpressure.
  id_ex_ctrl_t ex_ctrl;
  id_ex_ctrl_t id_ctrl;
  logic        hazard;

  assign id_ctrl = '{branch:   id_branch,
                     memread:  id_memread,
                     memtoreg: id_memtoreg,
                     memwrite: id_memwrite,
                     alusrc:   id_alusrc,
                     regwrite: id_regwrite,
                     aluop:    id_aluop};

  hazard_unit u_hazard (
    .ex_valid    (ex_valid),
    .ex_memread  (ex_ctrl.memread),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .flush       (flush),
    .hazard      (hazard),
    .bubble      (bubble),
    .pc_write    (pc_write),
    .if_id_write (if_id_write)
  );

  // Flush and bubble both load the all-zero NOP image; flush has priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid  <= 1'b0;
      ex_pc     <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_funct3 <= '0;
      ex_funct7 <= '0;
      ex_ctrl   <= CTRL_NOP;
    end else if (flush || bubble) begin
      ex_valid  <= 1'b0;
      ex_pc     <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_funct3 <= '0;
      ex_funct7 <= '0;
      ex_ctrl   <= CTRL_NOP;
    end else begin
      ex_valid  <= id_valid;
      ex_pc     <= id_pc;
      ex_rdata1 <= id_rdata1;
      ex_rdata2 <= id_rdata2;
      ex_imm    <= id_imm;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_rd     <= id_rd;
      ex_funct3 <= id_funct3;
      ex_funct7 <= id_funct7;
      ex_ctrl   <= id_valid ? id_ctrl : CTRL_NOP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (flush) begin
      if (flush_count != CNT_MAX) flush_count <= flush_count + CNT_ONE;
    end else if (bubble) begin
      if (stall_count != CNT_MAX) stall_count <= stall_count + CNT_ONE;
    end
  end

  assign ex_branch   = ex_ctrl.branch;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_aluop    = ex_ctrl.aluop;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: hazard/stall, flush priority, id_valid=0
// capture, counter saturation (narrow-counter instance) and async reset.
module tb_id_ex_stage;
  import rv_pipe_pkg::*;

  localparam int W = 64;

  logic          clk;
  logic          reset;
  logic          id_valid;
  logic [W-1:0]  id_pc, id_rdata1, id_rdata2, id_imm;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic [2:0]    id_funct3;
  logic [6:0]    id_funct7;
  logic          id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
  logic [1:0]    id_aluop;
  logic          flush;

  logic          bubble, pc_write, if_id_write, ex_valid;
  logic [W-1:0]  ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd;
  logic [2:0]    ex_funct3;
  logic [6:0]    ex_funct7;
  logic          ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
  logic [1:0]    ex_aluop;
  logic [31:0]   stall_count, flush_count;

  logic          s_bubble, s_pc_write, s_if_id_write, s_ex_valid;
  logic [W-1:0]  s_ex_pc, s_ex_rdata1, s_ex_rdata2, s_ex_imm;
  logic [4:0]    s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [2:0]    s_ex_funct3;
  logic [6:0]    s_ex_funct7;
  logic          s_ex_branch, s_ex_memread, s_ex_memtoreg, s_ex_memwrite, s_ex_alusrc, s_ex_regwrite;
  logic [1:0]    s_ex_aluop;
  logic [1:0]    s_stall_count, s_flush_count;

  int tests = 0;
  int fails = 0;

  id_ex_stage #(.XLEN(W), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_branch(id_branch), .id_memread(id_memread), .id_memtoreg(id_memtoreg),
    .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_aluop(id_aluop), .flush(flush),
    .bubble(bubble), .pc_write(pc_write), .if_id_write(if_id_write),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_branch(ex_branch), .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg),
    .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
    .ex_aluop(ex_aluop), .stall_count(stall_count), .flush_count(flush_count)
  );

  // Same stimulus, 2-bit counters so saturation is reachable in a few stalls.
  id_ex_stage #(.XLEN(W), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_branch(id_branch), .id_memread(id_memread), .id_memtoreg(id_memtoreg),
    .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_aluop(id_aluop), .flush(flush),
    .bubble(s_bubble), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rdata1(s_ex_rdata1), .ex_rdata2(s_ex_rdata2),
    .ex_imm(s_ex_imm), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
    .ex_funct3(s_ex_funct3), .ex_funct7(s_ex_funct7),
    .ex_branch(s_ex_branch), .ex_memread(s_ex_memread), .ex_memtoreg(s_ex_memtoreg),
    .ex_memwrite(s_ex_memwrite), .ex_alusrc(s_ex_alusrc), .ex_regwrite(s_ex_regwrite),
    .ex_aluop(s_ex_aluop), .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_funct3 = '0; id_funct7 = '0; id_rdata1 = '0; id_rdata2 = '0; id_imm = '0;
    id_branch = 1'b0; id_memread = 1'b0; id_memtoreg = 1'b0; id_memwrite = 1'b0;
    id_alusrc = 1'b0; id_regwrite = 1'b0; id_aluop = 2'b00; flush = 1'b0;
  endtask

  task automatic drive_rtype(input logic [W-1:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [W-1:0] d1);
    drive_idle();
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rdata1 = d1; id_rdata2 = 64'h7; id_regwrite = 1'b1; id_aluop = ALUOP_R;
  endtask

  task automatic drive_load(input logic [W-1:0] pc, input logic [4:0] rs1, input logic [4:0] rd);
    drive_idle();
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = 5'd0; id_rd = rd;
    id_imm = 64'h8; id_funct3 = 3'b011; id_memread = 1'b1; id_memtoreg = 1'b1;
    id_alusrc = 1'b1; id_regwrite = 1'b1; id_aluop = ALUOP_LDST;
  endtask

  initial begin
    drive_idle();
    reset = 1'b0;
    #1;
    check("rst_ex_valid", W'(ex_valid), 64'd0);
    check("rst_bubble", W'(bubble), 64'd0);
    check("rst_pc_write", W'(pc_write), 64'd1);
    check("rst_if_id_write", W'(if_id_write), 64'd1);
    check("rst_stall_count", W'(stall_count), 64'd0);
    check("rst_flush_count", W'(flush_count), 64'd0);
    step(); step();
    @(negedge clk);
    reset = 1'b1;

    // R-type passes through with one-cycle latency
    drive_rtype(64'h100, 5'd1, 5'd2, 5'd5, 64'd5);
    step();
    check("r_ex_regwrite", W'(ex_regwrite), 64'd1);
    check("r_ex_aluop", W'(ex_aluop), 64'd2);
    check("r_ex_rdata1", ex_rdata1, 64'd5);
    check("r_ex_valid", W'(ex_valid), 64'd1);
    check("r_ex_rd", W'(ex_rd), 64'd5);
    check("r_ex_pc", ex_pc, 64'h100);
    check("r_bubble", W'(bubble), 64'd0);

    // load x3 then use of x3 via rs2: one-cycle stall
    drive_load(64'h104, 5'd1, 5'd3);
    step();
    check("ld_ex_memread", W'(ex_memread), 64'd1);
    drive_rtype(64'h108, 5'd4, 5'd3, 5'd6, 64'h11);
    #1;
    check("lu_bubble", W'(bubble), 64'd1);
    check("lu_pc_write", W'(pc_write), 64'd0);
    check("lu_if_id_write", W'(if_id_write), 64'd0);
    step();
    check("lu_nop_valid", W'(ex_valid), 64'd0);
    check("lu_nop_memread", W'(ex_memread), 64'd0);
    check("lu_nop_regwrite", W'(ex_regwrite), 64'd0);
    check("lu_nop_memtoreg", W'(ex_memtoreg), 64'd0);
    check("lu_nop_rd", W'(ex_rd), 64'd0);
    check("lu_stall_count", W'(stall_count), 64'd1);
    check("lu_bubble_clear", W'(bubble), 64'd0);
    check("lu_pc_write_back", W'(pc_write), 64'd1);
    step();
    check("lu_use_valid", W'(ex_valid), 64'd1);
    check("lu_use_rd", W'(ex_rd), 64'd6);
    check("lu_use_rs2", W'(ex_rs2), 64'd3);

    // load to x0 never stalls
    drive_load(64'h10c, 5'd1, 5'd0);
    step();
    drive_rtype(64'h110, 5'd0, 5'd2, 5'd7, 64'h22);
    #1;
    check("x0_bubble", W'(bubble), 64'd0);
    step();
    check("x0_ex_valid", W'(ex_valid), 64'd1);
    check("x0_stall_count", W'(stall_count), 64'd1);

    // flush wins over a simultaneous load-use hazard
    drive_load(64'h114, 5'd1, 5'd7);
    step();
    drive_rtype(64'h118, 5'd7, 5'd2, 5'd8, 64'h33);
    flush = 1'b1;
    #1;
    check("fl_bubble", W'(bubble), 64'd0);
    check("fl_pc_write", W'(pc_write), 64'd1);
    step();
    flush = 1'b0;
    check("fl_ex_valid", W'(ex_valid), 64'd0);
    check("fl_ex_regwrite", W'(ex_regwrite), 64'd0);
    check("fl_ex_pc", ex_pc, 64'd0);
    check("fl_ex_rdata1", ex_rdata1, 64'd0);
    check("fl_flush_count", W'(flush_count), 64'd1);
    check("fl_stall_count", W'(stall_count), 64'd1);

    // id_valid=0: data captured, controls forced to 0
    drive_rtype(64'h11c, 5'd1, 5'd2, 5'd9, 64'h55);
    id_valid = 1'b0;
    step();
    check("iv0_ex_valid", W'(ex_valid), 64'd0);
    check("iv0_ex_regwrite", W'(ex_regwrite), 64'd0);
    check("iv0_ex_aluop", W'(ex_aluop), 64'd0);
    check("iv0_ex_rdata1", ex_rdata1, 64'h55);
    check("iv0_ex_rd", W'(ex_rd), 64'd9);

    // three more stalls: wide counter 4, 2-bit counter saturates at 3
    for (int i = 0; i < 3; i++) begin
      drive_load(64'h200, 5'd1, 5'd3);
      step();
      drive_rtype(64'h204, 5'd3, 5'd3, 5'd10, 64'h1);
      step();
      step();
    end
    check("sat_wide_stall", W'(stall_count), 64'd4);
    check("sat_narrow_stall", W'(s_stall_count), 64'd3);
    check("sat_narrow_flush", W'(s_flush_count), 64'd1);

    // async reset mid-cycle while EX holds a load
    drive_load(64'h300, 5'd1, 5'd3);
    step();
    check("ar_pre_memread", W'(ex_memread), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_ex_memread", W'(ex_memread), 64'd0);
    check("ar_ex_valid", W'(ex_valid), 64'd0);
    check("ar_ex_rd", W'(ex_rd), 64'd0);
    check("ar_stall_count", W'(stall_count), 64'd0);
    check("ar_flush_count", W'(flush_count), 64'd0);
    check("ar_bubble", W'(bubble), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("ar_restart_valid", W'(ex_valid), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
